// File: rtl/instr_cache_fill_ctlr_pkg.sv
// ----------------------------------------------------------------------------
// instr_cache_fill_ctlr_pkg
// Shared instruction-cache definitions: refill FSM state encoding and the
// block geometry helpers used by the cache controller, the cache sets and the
// refill engine.
// ----------------------------------------------------------------------------
package instr_cache_fill_ctlr_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} fill_state_t;

    // Default words per cache block (power of 2, >= 2).
    localparam int unsigned BLOCK_WORDS_DEF = 16;

    // Byte-offset bits within a block: word index bits plus 2 byte-select bits.
    function automatic int unsigned off_bits(input int unsigned block_words);
        return $clog2(block_words) + 2;
    endfunction

endpackage

// File: rtl/instr_cache_fill_ctlr.sv
// ----------------------------------------------------------------------------
// instr_cache_fill_ctlr
// Refill engine for the instruction cache. On a permitted miss it issues one
// block-aligned burst read, writes each returned beat into the victim way and
// pulses fill_done_o when the block is complete. A pipeline redirect abandons
// the fill: before the ack the request is dropped, after it the remaining
// beats are drained without being written.
//
// Ports
//   clk_i, reset_i          clock (rising edge), async active-low reset
//   instr_miss_f_i          fetch-set miss
//   instr_cache_rep_en_i    replacement permitted
//   pc_f_i                  PC of the missing instruction
//   flush_i                 pipeline redirect
//   mem_req_o/mem_addr_o    burst request and block address, held until ack
//   mem_ack_i               request accepted
//   mem_rvalid_i/rdata_i    read beats
//   fill_we_o/word_idx_o/data_o  cache word write, same cycle as the beat
//   fill_done_o             block complete pulse
//   fill_busy_o             fetch stall
// ----------------------------------------------------------------------------
module instr_cache_fill_ctlr
    import instr_cache_fill_ctlr_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           instr_miss_f_i,
    input  logic                           instr_cache_rep_en_i,
    input  logic [ADDR_WIDTH-1:0]          pc_f_i,
    input  logic                           flush_i,
    output logic                           mem_req_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    input  logic                           mem_ack_i,
    input  logic                           mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
    output logic                           fill_we_o,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx_o,
    output logic [DATA_WIDTH-1:0]          fill_data_o,
    output logic                           fill_done_o,
    output logic                           fill_busy_o
);

    localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF   = off_bits(BLOCK_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    fill_state_t             state_q, state_d;
    logic [IDX_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    abort_q, abort_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            abort_q    <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            abort_q    <= abort_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        abort_d         = abort_q;
        addr_d          = addr_q;
        mem_req_o       = 1'b0;
        mem_addr_o      = '0;
        fill_we_o       = 1'b0;
        fill_word_idx_o = beat_cnt_q;
        fill_data_o     = '0;
        fill_done_o     = 1'b0;
        fill_busy_o     = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // flush_i and stray beats have no effect here.
                if (instr_miss_f_i && instr_cache_rep_en_i) begin
                    addr_d  = pc_f_i & ~OFF_MASK;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = addr_q;
                if (mem_ack_i) begin
                    // Once accepted the burst must be drained, so a
                    // simultaneous flush only marks it aborted.
                    state_d    = RECV;
                    beat_cnt_d = '0;
                    abort_d    = flush_i;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                fill_we_o   = mem_rvalid_i & ~abort_q & ~flush_i;
                fill_data_o = mem_rdata_i;
                if (flush_i) begin
                    abort_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    beat_cnt_d = beat_cnt_q + IDX_W'(1);
                    if (beat_cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                fill_done_o = ~abort_q & ~flush_i;
                abort_d     = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_cache_fill_ctlr.sv
module tb_instr_cache_fill_ctlr;
    localparam int BW = 16;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          miss, rep, flush, ack, rvalid;
    logic [AW-1:0] pc;
    logic [DW-1:0] rdata;
    logic          mem_req_o, fill_we_o, fill_done_o, fill_busy_o;
    logic [AW-1:0] mem_addr_o;
    logic [IW-1:0] fill_word_idx_o;
    logic [DW-1:0] fill_data_o;

    instr_cache_fill_ctlr #(.BLOCK_WORDS(BW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .instr_miss_f_i(miss), .instr_cache_rep_en_i(rep), .pc_f_i(pc), .flush_i(flush),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(ack),
        .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
        .fill_we_o(fill_we_o), .fill_word_idx_o(fill_word_idx_o), .fill_data_o(fill_data_o),
        .fill_done_o(fill_done_o), .fill_busy_o(fill_busy_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A fill is "active" from the accepted miss until one cycle after the
    // last beat; while a request is outstanding it waits for ack; the cycle
    // after the final beat is the completion cycle.
    bit            m_active, m_req, m_done, m_abort;
    int            m_beats;
    logic [AW-1:0] m_addr;

    always @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            m_active <= 0; m_req <= 0; m_done <= 0; m_abort <= 0; m_beats <= 0; m_addr <= '0;
        end else if (!m_active) begin
            if (miss && rep) begin
                m_active <= 1; m_req <= 1; m_beats <= 0; m_abort <= 0;
                m_addr   <= (pc / (BW * 4)) * (BW * 4);
            end
        end else if (m_req) begin
            if (ack) begin
                m_req <= 0; m_beats <= 0; m_abort <= flush;
            end else if (flush) begin
                m_req <= 0; m_active <= 0;
            end
        end else if (m_done) begin
            m_active <= 0; m_done <= 0; m_abort <= 0;
        end else begin
            if (flush) m_abort <= 1;
            if (rvalid) begin
                m_beats <= m_beats + 1;
                if (m_beats + 1 == BW) m_done <= 1;
            end
        end
    end

    // ---------------- per-cycle compare + logging ----------------
    int            wr_idx[$];
    logic [DW-1:0] wr_data[$];
    int            n_done, n_req, done_cyc;
    logic [AW-1:0] req_addr;
    bit            e_recv, e_we;

    always @(negedge clk) begin
        if (reset_i) begin
            e_recv = m_active && !m_req && !m_done;
            e_we   = e_recv && rvalid && !m_abort && !flush;
            chk("busy", fill_busy_o, m_active);
            chk("mem_req", mem_req_o, m_req);
            if (m_req) chk("mem_addr", mem_addr_o, m_addr);
            chk("fill_we", fill_we_o, e_we);
            if (e_we) begin
                chk("fill_idx", fill_word_idx_o, m_beats);
                chk("fill_data", fill_data_o, rdata);
            end
            chk("fill_done", fill_done_o, m_done && !m_abort && !flush);
            if (fill_we_o) begin
                wr_idx.push_back(int'(fill_word_idx_o));
                wr_data.push_back(fill_data_o);
            end
            if (fill_done_o) begin n_done++; done_cyc = cyc; end
            if (mem_req_o) begin n_req++; req_addr = mem_addr_o; end
        end
    end

    // ---------------- stimulus ----------------
    int t_miss;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        wr_idx.delete(); wr_data.delete(); n_done = 0; n_req = 0; req_addr = '0; done_cyc = -1;
    endtask

    task automatic do_fill(input logic [AW-1:0] a, input bit gap, input int flush_at,
                           input logic [DW-1:0] dbase);
        miss = 1; rep = 1; pc = a; t_miss = cyc;
        step();
        miss = 0; rep = 0; ack = 1;
        step();
        ack = 0;
        for (int i = 0; i < BW; i++) begin
            rvalid = 1; rdata = dbase + DW'(i); flush = (i == flush_at);
            step();
            rvalid = 0; flush = 0; rdata = 32'hDEAD_BEEF;
            if (gap) step();
        end
        step();
    endtask

    task automatic chk_writes(input string tag, input int n, input logic [DW-1:0] dbase);
        chk({tag, "_nwrites"}, wr_idx.size(), n);
        for (int i = 0; i < n && i < wr_idx.size(); i++) begin
            chk({tag, "_idx"}, wr_idx[i], i);
            chk({tag, "_data"}, wr_data[i], dbase + DW'(i));
        end
    endtask

    initial begin
        reset_i = 0; miss = 0; rep = 0; flush = 0; ack = 0; rvalid = 0; pc = '0; rdata = '0;
        clear_log();
        #2;
        chk("rst_busy", fill_busy_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_done", fill_done_o, 0);
        step(); step();
        reset_i = 1;
        step();

        // Clean fill, zero-wait memory.
        clear_log();
        do_fill(32'h0000_1234, 0, -1, 32'h0);
        chk("clean_addr", req_addr, 32'h0000_1200);
        chk("clean_nreq", n_req, 1);
        chk_writes("clean", 16, 32'h0);
        chk("clean_ndone", n_done, 1);
        chk("clean_latency", done_cyc - t_miss, 18);

        // Gapped beats.
        clear_log();
        do_fill(32'h0000_ABCD, 1, -1, 32'hA500_0000);
        chk("gap_addr", req_addr, 32'h0000_ABC0);
        chk_writes("gap", 16, 32'hA500_0000);
        chk("gap_ndone", n_done, 1);

        // Miss without replacement permission; stray beat while idle.
        clear_log();
        miss = 1; rep = 0; pc = 32'h0000_2000;
        step(); step();
        miss = 0; rvalid = 1; rdata = 32'h1111_1111; flush = 1;
        step();
        rvalid = 0; flush = 0;
        step();
        chk("norep_nreq", n_req, 0);
        chk("norep_nwrites", wr_idx.size(), 0);
        chk("norep_busy", fill_busy_o, 0);

        // Flush in REQ before ack.
        clear_log();
        miss = 1; rep = 1; pc = 32'h0000_3000;
        step();
        miss = 0; rep = 0;
        chk("flreq_req_before", mem_req_o, 1);
        flush = 1;
        step();
        flush = 0;
        chk("flreq_req_after", mem_req_o, 0);
        chk("flreq_busy_after", fill_busy_o, 0);
        step(); step();
        chk("flreq_ndone", n_done, 0);

        // Flush together with ack: whole burst drained, nothing written.
        clear_log();
        miss = 1; rep = 1; pc = 32'h0000_5000;
        step();
        miss = 0; rep = 0; ack = 1; flush = 1;
        step();
        ack = 0; flush = 0;
        for (int i = 0; i < BW; i++) begin
            rvalid = 1; rdata = DW'(i);
            step();
        end
        rvalid = 0;
        chk("flack_busy_done_cycle", fill_busy_o, 1);
        step();
        chk("flack_nwrites", wr_idx.size(), 0);
        chk("flack_ndone", n_done, 0);
        chk("flack_idle", fill_busy_o, 0);

        // Flush at beat 5, then an immediate new miss.
        clear_log();
        do_fill(32'h0000_4000, 0, 5, 32'h100);
        chk_writes("fl5", 5, 32'h100);
        chk("fl5_ndone", n_done, 0);
        chk("fl5_idle", fill_busy_o, 0);
        clear_log();
        do_fill(32'h8000_0044, 0, -1, 32'h200);
        chk("refill_addr", req_addr, 32'h8000_0040);
        chk_writes("refill", 16, 32'h200);
        chk("refill_ndone", n_done, 1);

        // Asynchronous reset in the middle of a burst.
        clear_log();
        miss = 1; rep = 1; pc = 32'h0000_6000;
        step();
        miss = 0; rep = 0; ack = 1;
        step();
        ack = 0; rvalid = 1; rdata = 32'h5555_5555;
        step(); step(); step();
        #2;
        reset_i = 0;
        #1;
        chk("arst_busy", fill_busy_o, 0);
        chk("arst_req", mem_req_o, 0);
        chk("arst_addr", mem_addr_o, 0);
        chk("arst_we", fill_we_o, 0);
        chk("arst_idx", fill_word_idx_o, 0);
        chk("arst_data", fill_data_o, 0);
        chk("arst_done", fill_done_o, 0);
        step();
        rvalid = 0; reset_i = 1;
        step();
        clear_log();
        do_fill(32'h0000_7010, 0, -1, 32'h300);
        chk_writes("post_rst", 16, 32'h300);
        chk("post_rst_ndone", n_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
